xbar_pipe_nxw: RTL and testbench
================================

Name: xbar_pipe_nxw

Overview:
- Parametrised, pipelined successor to the fixed 4x2b combinational passthrough.
- Routes NCH input channels of W bits each to NCH output channels through a runtime-programmable crossbar, then through LAT register stages.
- Carries a valid bit alongside the data and supports a global stall.
- After reset the select table is the identity, so the block behaves as a registered N-by-W passthrough.

Parameters:
- NCH, 4, number of channels (>= 2).
- W, 2, bits per channel (>= 1).
- LAT, 1, pipeline stages from input to output (>= 1).
- SELW, $clog2(NCH), derived; width of one select field.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 0 stalls all stages.
- in_val  input  1  input word valid.
- in_data  input  NCH*W  channel i at bits [i*W +: W].
- sel_wen  input  1  select-table write strobe.
- sel_wdata  input  NCH*SELW  sel for output i at bits [i*SELW +: SELW].
- out_val  output  1  valid of final stage.
- out_data  output  NCH*W  output channel i at bits [i*W +: W].
- sel_q  output  NCH*SELW  current select table, for readback.

Behaviour:
- Routing:
  - Stage-0 input for channel i is in_data channel sel_q[i], applied combinationally at capture.
  - A select value >= NCH routes constant 0 to that channel.
  - Broadcast (several outputs sharing one sel) is legal.
- Pipeline:
  - LAT stages, each holding a valid bit and NCH*W data bits. out_val/out_data are the last stage.
  - When en=1: stage 0 loads {in_val, routed data}; stage k loads stage k-1.
  - When en=0: all stages hold. in_val/in_data are ignored that cycle (dropped, not queued).
  - Data registers load whenever en=1, regardless of valid, so out_data is deterministic.
  - Latency is exactly LAT enabled cycles from capture to out_val=1.
- Select table:
  - On sel_wen=1, sel_q <= sel_wdata at the clock edge, independent of en.
  - A word captured in the same cycle as sel_wen uses the OLD table.
  - Words already in the pipeline are never re-routed.
- Reset (takes priority over en and sel_wen):
  - All valid bits 0 and all data bits 0, so out_val=0 and out_data=0.
  - sel_q is the identity: field i = i.
  - Reset asserted mid-stream discards in-flight words. First capture is allowed the cycle after reset deasserts.
- No combinational path from any input to out_val/out_data. sel_q is registered.

Decomposition:
- Shared package xbar_pkg:
  - identity-select constant function idsel(NCH).
  - SELW localparam helper.
- One sub-module, xbar_pipe_stage: a W*NCH+1-bit register with enable and synchronous reset, instantiated LAT times via generate.
- The crossbar mux stays in the top module.

Test Plan (NCH=4, W=2, LAT=2 unless noted):
- Reset, then in_val=1, in_data=0xE4 (ch0..3 = 0,1,2,3), en=1 -> out_val=0 after 1 cycle; out_val=1, out_data=0xE4 after 2 cycles. Verifies identity passthrough.
- sel_wen=1, sel_wdata=0x1B (reverse), then in 0xE4 -> out_data=0x1B after LAT. Then sel_wdata=0xAA (broadcast ch2), in 0xE4 -> out 0xAA.
- Same-cycle sel_wen=0x1B with in 0xE4 -> out 0xE4 (old table). Next input 0xE4 -> out 0x1B.
- Stream 0x00, 0x55, 0xAA with en=0 for 3 cycles between the 1st and 2nd words:
  - outputs hold during the stall;
  - out sequence is exactly 0x00, 0x55, 0xAA with no duplication or loss;
  - in_val asserted during the stall is dropped.
- Reset asserted while 2 words are in flight -> next cycle out_val=0, out_data=0, sel_q=0xE4 (identity). A post-reset word appears after LAT cycles.
- LAT=1, NCH=8, W=3: random inputs and random select tables (including out-of-range fields for NCH that is not a power of two, tested with NCH=5) -> matches the reference model every cycle.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared helpers for the pipelined crossbar: select-field width and the
// identity select table loaded at reset.
package xbar_pkg;

  localparam int unsigned IDSEL_MAXW = 1024;

  function automatic int unsigned selw_of(input int unsigned nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

  // Field i of the returned table holds the value i; upper bits are zero.
  function automatic logic [IDSEL_MAXW-1:0] idsel(input int unsigned nch);
    logic [IDSEL_MAXW-1:0] r;
    int unsigned           sw;
    r  = '0;
    sw = selw_of(nch);
    for (int unsigned i = 0; i < nch; i++) begin
      for (int unsigned b = 0; b < sw; b++) begin
        if ((i * sw + b) < IDSEL_MAXW) r[10'(i * sw + b)] = i[5'(b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_pipe_nxw_stage.sv
// One pipeline stage: a DW-bit register with load enable and synchronous reset.
module xbar_pipe_stage #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/xbar_pipe_nxw.sv
// NCH x W runtime-programmable crossbar feeding a LAT-deep stallable pipeline
// carrying a valid bit alongside the routed data.
module xbar_pipe_nxw
  import xbar_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned W    = 2,
  parameter int unsigned LAT  = 1,
  parameter int unsigned SELW = selw_of(NCH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in_val,
  input  logic [NCH*W-1:0]    in_data,
  input  logic                sel_wen,
  input  logic [NCH*SELW-1:0] sel_wdata,
  output logic                out_val,
  output logic [NCH*W-1:0]    out_data,
  output logic [NCH*SELW-1:0] sel_q
);

  localparam int unsigned DW     = NCH * W;
  localparam int unsigned SW_TOT = NCH * SELW;
  localparam logic [IDSEL_MAXW-1:0] ID_FULL = idsel(NCH);
  localparam logic [SW_TOT-1:0]     ID_SEL  = ID_FULL[SW_TOT-1:0];

  logic [SW_TOT-1:0] r_sel;
  logic [DW-1:0]     w_routed;
  logic [DW:0]       w_stage_q [LAT];

  // Select table; a write lands at the edge, so a same-cycle capture sees the old table.
  always_ff @(posedge clk) begin
    if (reset)        r_sel <= ID_SEL;
    else if (sel_wen) r_sel <= sel_wdata;
  end

  // Crossbar: out-of-range select values match no input and leave the channel at zero.
  always_comb begin
    w_routed = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned j = 0; j < NCH; j++) begin
        if (r_sel[i*SELW +: SELW] == SELW'(j)) w_routed[i*W +: W] = in_data[j*W +: W];
      end
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    logic [DW:0] w_d;
    if (k == 0) begin : g_first
      assign w_d = {in_val, w_routed};
    end else begin : g_next
      assign w_d = w_stage_q[k-1];
    end
    xbar_pipe_stage #(.DW(DW + 1)) u_stage (
      .clk   (clk),
      .reset (reset),
      .i_en  (en),
      .i_d   (w_d),
      .o_q   (w_stage_q[k])
    );
  end

  assign out_val  = w_stage_q[LAT-1][DW];
  assign out_data = w_stage_q[LAT-1][DW-1:0];
  assign sel_q    = r_sel;

endmodule

// File: tb/tb_xbar_pipe_nxw.sv
// Bench for xbar_pipe_nxw: directed 4x2/LAT=2 scenarios through a latency-aware
// scoreboard, plus randomized 8x3 and 5x3 LAT=1 instances against a cycle model.
module tb_xbar_pipe_nxw;

  localparam int LAT_A = 2;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NCH=4, W=2, LAT=2
  logic       reset, en, in_val, sel_wen;
  logic [7:0] in_data, sel_wdata;
  logic       out_val;
  logic [7:0] out_data, sel_q;

  xbar_pipe_nxw #(.NCH(4), .W(2), .LAT(LAT_A)) u_a (
    .clk(clk), .reset(reset), .en(en), .in_val(in_val), .in_data(in_data),
    .sel_wen(sel_wen), .sel_wdata(sel_wdata),
    .out_val(out_val), .out_data(out_data), .sel_q(sel_q)
  );

  // Instance B: NCH=8, W=3, LAT=1 ; Instance C: NCH=5, W=3, LAT=1
  logic        rst_r;
  logic        en_b, val_b, wen_b, oval_b;
  logic [23:0] data_b, wd_b, odata_b, selq_b;
  logic        en_c, val_c, wen_c, oval_c;
  logic [14:0] data_c, wd_c, odata_c, selq_c;

  xbar_pipe_nxw #(.NCH(8), .W(3), .LAT(1)) u_b (
    .clk(clk), .reset(rst_r), .en(en_b), .in_val(val_b), .in_data(data_b),
    .sel_wen(wen_b), .sel_wdata(wd_b),
    .out_val(oval_b), .out_data(odata_b), .sel_q(selq_b)
  );

  xbar_pipe_nxw #(.NCH(5), .W(3), .LAT(1)) u_c (
    .clk(clk), .reset(rst_r), .en(en_c), .in_val(val_c), .in_data(data_c),
    .sel_wen(wen_c), .sel_wdata(wd_c),
    .out_val(oval_c), .out_data(odata_c), .sel_q(selq_c)
  );

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;
  exp_t sb[$];
  int   ecnt = 0;
  logic       prev_val;
  logic [7:0] prev_data;

  typedef struct {
    logic       wen;
    logic [7:0] wdata;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [7:0] exp_sel;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of instance A; an accepted word is expected LAT_A enabled edges later.
  task automatic cyc(input logic e, input logic v, input logic [7:0] d,
                     input logic w, input logic [7:0] wd, input logic [7:0] exp_d);
    en = e; in_val = v; in_data = d; sel_wen = w; sel_wdata = wd;
    if (e && v) sb.push_back('{d: exp_d, due: ecnt + LAT_A});
    @(posedge clk); #1;
    if (e) begin
      ecnt++;
      if (sb.size() > 0 && sb[0].due == ecnt) begin
        chk("out_val_word", 64'(out_val), 64'(1));
        chk("out_data_word", 64'(out_data), 64'(sb[0].d));
        void'(sb.pop_front());
      end else begin
        chk("out_val_idle", 64'(out_val), 64'(0));
      end
    end else begin
      chk("stall_hold_val", 64'(out_val), 64'(prev_val));
      chk("stall_hold_data", 64'(out_data), 64'(prev_data));
    end
    prev_val  = out_val;
    prev_data = out_data;
    en = 1'b0; in_val = 1'b0; sel_wen = 1'b0;
  endtask

  task automatic rst_cyc();
    reset = 1'b1; en = 1'b1; in_val = 1'b1; in_data = 8'h3C;
    sel_wen = 1'b1; sel_wdata = 8'h00;
    @(posedge clk); #1;
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_sel_q", 64'(sel_q), 64'h0E4);
    sb.delete();
    prev_val = 1'b0; prev_data = 8'h00;
    reset = 1'b0; en = 1'b0; in_val = 1'b0; sel_wen = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [63:0] route(input logic [63:0] din, input logic [63:0] sel,
                                        input int nch, input int w, input int sw);
    logic [63:0] r;
    int          s;
    r = '0;
    for (int i = 0; i < nch; i++) begin
      s = 0;
      for (int b = 0; b < sw; b++) if (sel[i*sw+b]) s = s | (1 << b);
      if (s < nch) for (int b = 0; b < w; b++) r[i*w+b] = din[s*w+b];
    end
    return r;
  endfunction

  function automatic logic [63:0] tb_id(input int nch, input int sw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nch; i++)
      for (int b = 0; b < sw; b++) r[i*sw+b] = ((i >> b) & 1) != 0;
    return r;
  endfunction

  logic        mb_val, mc_val;
  logic [63:0] mb_data, mc_data, mb_sel, mc_sel;

  initial begin
    reset = 1'b1; en = 1'b0; in_val = 1'b0; in_data = '0; sel_wen = 1'b0; sel_wdata = '0;
    rst_r = 1'b1;
    en_b = 1'b0; val_b = 1'b0; wen_b = 1'b0; data_b = '0; wd_b = '0;
    en_c = 1'b0; val_c = 1'b0; wen_c = 1'b0; data_c = '0; wd_c = '0;
    prev_val = 1'b0; prev_data = 8'h00;

    // {wen, wdata, din, expected out, expected sel_q after the edge}
    tbl[0] = '{1'b0, 8'h00, 8'hE4, 8'hE4, 8'hE4};
    tbl[1] = '{1'b1, 8'h1B, 8'hE4, 8'hE4, 8'h1B};
    tbl[2] = '{1'b0, 8'h00, 8'hE4, 8'h1B, 8'h1B};
    tbl[3] = '{1'b1, 8'hAA, 8'hE4, 8'h1B, 8'hAA};
    tbl[4] = '{1'b0, 8'h00, 8'hE4, 8'hAA, 8'hAA};
    tbl[5] = '{1'b1, 8'hE4, 8'h1B, 8'h55, 8'hE4};
    tbl[6] = '{1'b0, 8'h00, 8'h1B, 8'h1B, 8'hE4};

    @(posedge clk); #1;
    rst_cyc();

    // Identity passthrough, single word
    cyc(1'b1, 1'b1, 8'hE4, 1'b0, 8'h00, 8'hE4);
    drain();

    // Table: reverse, broadcast, same-cycle writes, back-to-back words
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, tbl[i].din, tbl[i].wen, tbl[i].wdata, tbl[i].exp_out);
      chk("tbl_sel_q", 64'(sel_q), 64'(tbl[i].exp_sel));
    end
    drain();

    // Stream with a 3-cycle stall; in_val during the stall must be dropped
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 8'h55);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 8'hAA);
    drain();

    // Reset with two words in flight under a non-identity table
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h1B, 8'h00);
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'h44);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 8'h88);
    cyc(1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 8'hCC);
    rst_cyc();
    cyc(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h5A);
    drain();

    // Randomized LAT=1 instances against a per-cycle model
    for (int n = 0; n < 400; n++) begin
      if (rst_r) begin
        mb_val = 1'b0; mb_data = '0; mb_sel = tb_id(8, 3);
        mc_val = 1'b0; mc_data = '0; mc_sel = tb_id(5, 3);
      end else begin
        if (en_b) begin mb_val = val_b; mb_data = route(64'(data_b), mb_sel, 8, 3, 3); end
        if (wen_b) mb_sel = 64'(wd_b);
        if (en_c) begin mc_val = val_c; mc_data = route(64'(data_c), mc_sel, 5, 3, 3); end
        if (wen_c) mc_sel = 64'(wd_c);
      end
      @(posedge clk); #1;
      chk("rnd_b_val", 64'(oval_b), 64'(mb_val));
      chk("rnd_b_data", 64'(odata_b), mb_data);
      chk("rnd_b_sel", 64'(selq_b), mb_sel);
      chk("rnd_c_val", 64'(oval_c), 64'(mc_val));
      chk("rnd_c_data", 64'(odata_c), mc_data);
      chk("rnd_c_sel", 64'(selq_c), mc_sel);
      rst_r  = ($urandom_range(0, 63) == 0);
      en_b   = ($urandom_range(0, 4) != 0);
      val_b  = 1'($urandom_range(0, 1));
      wen_b  = ($urandom_range(0, 3) == 0);
      data_b = 24'($urandom);
      wd_b   = 24'($urandom);
      en_c   = ($urandom_range(0, 4) != 0);
      val_c  = 1'($urandom_range(0, 1));
      wen_c  = ($urandom_range(0, 3) == 0);
      data_c = 15'($urandom);
      wd_c   = 15'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
